uart_parity_tx_sm: RTL

//  UART transmitter (master side) for the 9-bit parity receiver path. Serialises a byte as

---
 rtl/uart_parity_tx_sm.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_parity_tx_sm.sv
// -----------------------------------------------------------------------------
// uart_parity_tx_sm
// UART transmitter feeding the 9-bit parity receiver path. A byte is sent as
// start(0), d0..d7 LSB first, parity, stop(1): 11 bit periods per frame.
// Each bit is held CLKS_PER_BIT clk cycles. The line idles high.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per bit period (>= 1)
//   PARITY_ODD   : 0 = even parity (^data), 1 = odd parity (~^data)
//
// Ports
//   clk        in   single clock, all state changes on posedge
//   reset      in   asynchronous active-high reset
//   tx_data    in   byte to send, sampled only on acceptance
//   tx_valid   in   host offers tx_data
//   tx_ready   out  combinational: byte accepted this cycle if tx_valid
//   abort      in   synchronous active-high frame kill (receiver reset request)
//   Tx_out     out  registered serial line
//   busy       out  registered, high whenever the FSM is not IDLE
//   frame_done out  registered, high on the last clk of the STOP bit period
//
// Build option
//   UART_TX_HOLD_BUF_EN : adds a one-entry holding register so a byte can be
//   accepted while a frame is in flight and sent with zero idle cycles.
//   Undefined: no buffer, at least one idle cycle between frames.
// -----------------------------------------------------------------------------
module uart_parity_tx_sm #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic       Tx_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef UART_TX_HOLD_BUF_EN
    logic [7:0]        buf_data_q, buf_data_d;
    logic              buf_par_q, buf_par_d;
    logic              buf_full_q, buf_full_d;
`endif

    logic              baud_last;
    logic              accept;
    logic              in_par;

    // Parity of the incoming byte, computed at acceptance so the frame never
    // depends on tx_data again.
    assign in_par    = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
    assign baud_last = (baud_q == BAUD_LAST);

`ifdef UART_TX_HOLD_BUF_EN
    assign tx_ready = ~abort && ((state_q == S_IDLE) || !buf_full_q);
`else
    assign tx_ready = ~abort && (state_q == S_IDLE);
`endif

    assign accept = tx_valid && tx_ready;

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
`ifdef UART_TX_HOLD_BUF_EN
        buf_data_d = buf_data_q;
        buf_par_d  = buf_par_q;
        buf_full_d = buf_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    par_d   = in_par;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    idx_d   = '0;
                end
            end

            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    baud_d  = '0;
                    idx_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                    // Chain the next frame with no idle gap: buffered byte
                    // first, otherwise a byte accepted on this very edge.
                    if (buf_full_q) begin
                        state_d    = S_START;
                        shift_d    = buf_data_q;
                        par_d      = buf_par_q;
                        tx_d       = 1'b0;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = S_START;
                        shift_d = tx_data;
                        par_d   = in_par;
                        tx_d    = 1'b0;
                    end
`endif
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
                idx_d   = '0;
            end
        endcase

`ifdef UART_TX_HOLD_BUF_EN
        // Mid-frame acceptance parks the byte; the final-STOP case above
        // already consumed it directly.
        if (accept && (state_q != S_IDLE) && !((state_q == S_STOP) && baud_last)) begin
            buf_data_d = tx_data;
            buf_par_d  = in_par;
            buf_full_d = 1'b1;
        end
`endif

        // Abort overrides everything on this edge.
        if (abort) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            baud_d  = '0;
            idx_d   = '0;
`ifdef UART_TX_HOLD_BUF_EN
            buf_full_d = 1'b0;
`endif
        end

        busy_d = (state_d != S_IDLE);
        // Registered pulse lands on the last clk of the STOP period.
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data_q <= '0;
            buf_par_q  <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_par_q  <= buf_par_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign Tx_out     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
